// File: rtl/motor_drive.sv
// motor_drive: motor bridge controller with a ramped PWM duty, braking and
// dead time on direction reversal, and fault lockout.
// Ports:
//   clk, rst_n - clock; asynchronous active-low reset
//   speed_o    - target speed (0 = stop)
//   dir_o      - target direction code
//   fault      - faulty-module flags; any nonzero bit forces FAULT
//   pwm        - registered PWM drive, equal to en && (pwm counter < duty)
//   en         - registered bridge enable
//   dir_q      - direction code currently applied to the bridge
//   duty       - current ramped duty value
//   state_q    - FSM state code (IDLE=0, RUN=1, BRAKE=2, DEAD=3, FAULT=4)
module motor_drive #(
    parameter int unsigned RAMP_DIV  = 4,
    parameter int unsigned DEAD_TIME = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] speed_o,
    input  logic [3:0] dir_o,
    input  logic [2:0] fault,
    output logic       pwm,
    output logic       en,
    output logic [3:0] dir_q,
    output logic [3:0] duty,
    output logic [2:0] state_q
);

    localparam int unsigned PW = (RAMP_DIV  > 1) ? $clog2(RAMP_DIV)  : 1;
    localparam int unsigned DW = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        BRAKE = 3'd2,
        DEAD  = 3'd3,
        FAULT = 3'd4
    } state_e;

    state_e        fsm_q, fsm_d;
    logic [3:0]    duty_q, duty_d;
    logic          en_q, en_d;
    logic          pwm_q, pwm_d;
    logic [3:0]    dir_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [DW-1:0] dead_q, dead_d;
    logic          ramp_tick;

    // Free-running PWM counter and ramp prescaler
    assign ramp_tick = (pre_q == PW'(RAMP_DIV - 1));
    assign cnt_d     = cnt_q + 4'd1;
    assign pre_d     = ramp_tick ? '0 : pre_q + PW'(1);

    // Next-state and next-output logic
    always_comb begin
        fsm_d  = fsm_q;
        duty_d = duty_q;
        en_d   = en_q;
        dir_d  = dir_q;
        dead_d = '0;

        if (fault != 3'd0) begin
            // Fault overrides everything, including a pending transition
            fsm_d  = FAULT;
            duty_d = 4'd0;
            en_d   = 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    duty_d = 4'd0;
                    en_d   = 1'b0;
                    if (speed_o != 4'd0) begin
                        fsm_d = RUN;
                        dir_d = dir_o;
                        en_d  = 1'b1;
                    end
                end
                RUN: begin
                    en_d = 1'b1;
                    if (dir_o != dir_q) begin
                        // Reversal: brake down first unless already stopped
                        if (duty_q != 4'd0) begin
                            fsm_d = BRAKE;
                        end else begin
                            fsm_d = DEAD;
                            en_d  = 1'b0;
                        end
                    end else if ((speed_o == 4'd0) && (duty_q == 4'd0)) begin
                        fsm_d = IDLE;
                        en_d  = 1'b0;
                    end else if (ramp_tick) begin
                        if (duty_q < speed_o) begin
                            duty_d = duty_q + 4'd1;
                        end else if (duty_q > speed_o) begin
                            duty_d = duty_q - 4'd1;
                        end
                    end
                end
                BRAKE: begin
                    // Committed: a direction flip back does not abort braking
                    en_d = 1'b1;
                    if (duty_q == 4'd0) begin
                        fsm_d = DEAD;
                        en_d  = 1'b0;
                    end else if (ramp_tick) begin
                        duty_d = duty_q - 4'd1;
                    end
                end
                DEAD: begin
                    duty_d = 4'd0;
                    en_d   = 1'b0;
                    if (dead_q == DW'(DEAD_TIME - 1)) begin
                        dir_d = dir_o;
                        if (speed_o != 4'd0) begin
                            fsm_d = RUN;
                            en_d  = 1'b1;
                        end else begin
                            fsm_d = IDLE;
                        end
                    end else begin
                        dead_d = dead_q + DW'(1);
                    end
                end
                FAULT: begin
                    duty_d = 4'd0;
                    en_d   = 1'b0;
                    fsm_d  = IDLE;
                end
                default: begin
                    duty_d = 4'd0;
                    en_d   = 1'b0;
                    fsm_d  = IDLE;
                end
            endcase
        end
    end

    // PWM compare uses next-cycle values so pwm, en and duty stay coherent
    assign pwm_d = en_d & (cnt_d < duty_d);

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q  <= IDLE;
            duty_q <= 4'd0;
            en_q   <= 1'b0;
            pwm_q  <= 1'b0;
            dir_q  <= 4'd0;
            cnt_q  <= 4'd0;
            pre_q  <= '0;
            dead_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            duty_q <= duty_d;
            en_q   <= en_d;
            pwm_q  <= pwm_d;
            dir_q  <= dir_d;
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            dead_q <= dead_d;
        end
    end

    assign pwm     = pwm_q;
    assign en      = en_q;
    assign duty    = duty_q;
    assign state_q = fsm_q;

endmodule

// File: tb/tb_motor_drive.sv
// tb_motor_drive: directed scenarios plus randomized traffic for motor_drive,
// checked every cycle against a behavioural model of the drive.
module tb_motor_drive;

    localparam int RAMP_DIV  = 4;
    localparam int DEAD_TIME = 8;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_BRAKE = 2;
    localparam int S_DEAD  = 3;
    localparam int S_FAULT = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] spd;
    logic [3:0] dirv;
    logic [2:0] flt;
    logic       pwm;
    logic       en;
    logic [3:0] dir_q;
    logic [3:0] duty;
    logic [2:0] state_q;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model of the drive
    int m_state, m_duty, m_en, m_pwm, m_dir, m_cnt, m_pre, m_dead_cycles;

    motor_drive #(
        .RAMP_DIV (RAMP_DIV),
        .DEAD_TIME(DEAD_TIME)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .speed_o(spd),
        .dir_o  (dirv),
        .fault  (flt),
        .pwm    (pwm),
        .en     (en),
        .dir_q  (dir_q),
        .duty   (duty),
        .state_q(state_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_duty = 0; m_en = 0; m_pwm = 0;
        m_dir = 0; m_cnt = 0; m_pre = 0; m_dead_cycles = 0;
    endtask

    // One rising edge of the drive, from the inputs present at that edge
    task automatic model_edge();
        bit tick;
        int nxt;
        int up;
        int dn;
        tick  = (m_pre == RAMP_DIV - 1);
        nxt   = m_state;
        m_cnt = (m_cnt + 1) % 16;
        m_pre = (m_pre + 1) % RAMP_DIV;
        if (flt != 0) begin
            nxt = S_FAULT; m_duty = 0; m_en = 0;
        end else if (m_state == S_IDLE) begin
            if (spd != 0) begin
                nxt = S_RUN; m_dir = int'(dirv); m_en = 1;
            end
        end else if (m_state == S_RUN) begin
            if (int'(dirv) != m_dir) begin
                if (m_duty > 0) nxt = S_BRAKE;
                else begin nxt = S_DEAD; m_en = 0; m_dead_cycles = 1; end
            end else if (spd == 0 && m_duty == 0) begin
                nxt = S_IDLE; m_en = 0;
            end else if (tick) begin
                up = (int'(spd) > m_duty) ? 1 : 0;
                dn = (int'(spd) < m_duty) ? 1 : 0;
                m_duty = m_duty + up - dn;
            end
        end else if (m_state == S_BRAKE) begin
            if (m_duty == 0) begin
                nxt = S_DEAD; m_en = 0; m_dead_cycles = 1;
            end else if (tick) begin
                m_duty = m_duty - 1;
            end
        end else if (m_state == S_DEAD) begin
            if (m_dead_cycles >= DEAD_TIME) begin
                m_dir = int'(dirv);
                if (spd != 0) begin nxt = S_RUN; m_en = 1; end
                else nxt = S_IDLE;
            end else begin
                m_dead_cycles++;
            end
        end else begin
            nxt = S_IDLE; m_duty = 0; m_en = 0;
        end
        m_state = nxt;
        m_pwm = (m_en != 0 && m_cnt < m_duty) ? 1 : 0;
    endtask

    task automatic check_all();
        chk("state", 32'(state_q), m_state);
        chk("duty",  32'(duty),    m_duty);
        chk("en",    32'(en),      m_en);
        chk("pwm",   32'(pwm),     m_pwm);
        chk("dir_q", 32'(dir_q),   m_dir);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset pulse between clock edges, held across one edge
    task automatic async_reset_pulse();
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int pwm_hi;
        int en_lo;
        int pwm_bad;
        int flt_left;

        rst_n = 1'b0; spd = 4'd10; dirv = 4'd5; flt = 3'd0;
        model_reset();
        steps(2);
        chk("rst_state", 32'(state_q), S_IDLE);
        chk("rst_duty",  32'(duty), 0);
        chk("rst_en_pwm", 32'({en, pwm}), 0);

        // Ramp-up to 10 in direction 5
        rst_n = 1'b1;
        step();
        chk("run_entry_state", 32'(state_q), S_RUN);
        chk("run_entry_dir",   32'(dir_q), 5);
        steps(44);
        chk("ramp_duty10", 32'(duty), 10);
        pwm_hi = 0;
        for (int i = 0; i < 16; i++) begin step(); pwm_hi += int'(pwm); end
        chk("pwm_high_of_16", pwm_hi, 10);

        // Reversal 5 -> 6 through BRAKE and DEAD
        dirv = 4'd6;
        en_lo = 0; pwm_bad = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (!en) en_lo++;
            if (pwm && !en) pwm_bad++;
        end
        chk("dead_en_low_cycles", en_lo, DEAD_TIME);
        chk("pwm_while_disabled", pwm_bad, 0);
        chk("reversed_dir", 32'(dir_q), 6);
        steps(45);
        chk("reramp_duty10", 32'(duty), 10);

        // Fault at full duty, with a clear/reassert glitch between edges
        spd = 4'd15;
        steps(24);
        chk("full_duty", 32'(duty), 15);
        flt = 3'b010;
        step();
        chk("fault_state", 32'(state_q), S_FAULT);
        chk("fault_outputs", 32'({pwm, en, duty}), 0);
        flt = 3'd0;
        #2 flt = 3'b001;
        step();
        chk("fault_glitch_held", 32'(state_q), S_FAULT);
        flt = 3'd0;
        step();
        chk("fault_to_idle", 32'(state_q), S_IDLE);
        step();
        chk("fault_rerun_state", 32'(state_q), S_RUN);
        chk("fault_rerun_duty", 32'(duty), 0);
        steps(64);
        chk("fault_reramp_duty15", 32'(duty), 15);

        // Stop from duty 6
        spd = 4'd6;
        steps(40);
        chk("stop_start_duty6", 32'(duty), 6);
        spd = 4'd0;
        steps(30);
        chk("stop_idle", 32'(state_q), S_IDLE);
        chk("stop_en", 32'(en), 0);
        chk("stop_dir_kept", 32'(dir_q), 6);

        // Retarget at duty 8 and saturation at 15
        spd = 4'd15;
        for (int i = 0; i < 80 && m_duty != 8; i++) step();
        chk("retarget_at8", 32'(duty), 8);
        spd = 4'd3;
        steps(4);
        chk("retarget_no_rise", 32'(duty <= 4'd8), 1);
        steps(30);
        chk("retarget_duty3", 32'(duty), 3);
        spd = 4'd15;
        steps(60);
        chk("saturate15", 32'(duty), 15);
        steps(8);
        chk("saturate15_hold", 32'(duty), 15);

        // Reset pulse during DEAD
        dirv = 4'd9;
        for (int i = 0; i < 100 && m_state != S_DEAD; i++) step();
        chk("reach_dead", 32'(state_q), S_DEAD);
        steps(3);
        async_reset_pulse();
        chk("midrst_dir", 32'(dir_q), 0);
        chk("midrst_state", 32'(state_q), S_IDLE);
        step();
        chk("postrst_run", 32'(state_q), S_RUN);
        chk("postrst_dir", 32'(dir_q), 9);

        // Randomized traffic
        flt_left = 0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 19) == 0) spd = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) dirv = 4'($urandom_range(0, 15));
            if (flt_left > 0) begin
                flt_left--;
                flt = 3'($urandom_range(1, 7));
            end else begin
                flt = 3'd0;
                if ($urandom_range(0, 249) == 0) flt_left = $urandom_range(1, 4);
            end
            if ($urandom_range(0, 599) == 0) async_reset_pulse();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/motor_drive.md
MOTOR_DRIVE -- requirements
Module: motor_drive

Interface
REQ-001 Parameter: RAMP_DIV, 4, clock cycles per ramp step (>=1).
REQ-002 Parameter: DEAD_TIME, 8, cycles the bridge is disabled across a direction change (>=1).
REQ-003 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: speed_o  input  4  target speed from the redundancy stage (0 = stop).
REQ-006 Port: dir_o  input  4  target direction code from the redundancy stage.
REQ-007 Port: fault  input  3  faulty-module flags from the redundancy stage; nonzero = fault.
REQ-008 Port: pwm  output  1  registered PWM drive to the motor bridge.
REQ-009 Port: en  output  1  registered bridge enable.
REQ-010 Port: dir_q  output  4  direction code currently applied to the bridge.
REQ-011 Port: duty  output  4  current ramped duty value.
REQ-012 Port: state_q  output  3  FSM state code, for monitoring.

Function
REQ-013 The FSM SHALL have states IDLE=0, RUN=1, BRAKE=2, DEAD=3, FAULT=4; other codes go to IDLE.
REQ-014 A 4-bit PWM counter SHALL free-run 0..15 and wrap; pwm SHALL be registered as en AND (counter < duty); period 16 cycles, duty 15 gives 15/16 high, duty 0 gives constant low.
REQ-015 A ramp prescaler SHALL free-run 0..RAMP_DIV-1; a ramp tick is the cycle it equals RAMP_DIV-1.
REQ-016 In any state, fault != 0 SHALL move to FAULT on the next edge, with duty, pwm and en all 0 from that edge; this has priority over every other transition.
REQ-017 FAULT: duty=0, en=0, dir_q held; on fault == 0, go to IDLE next edge; a fault clearing and reasserting within one cycle SHALL keep FAULT.
REQ-018 IDLE: duty=0, en=0; on speed_o != 0, load dir_q <= dir_o, set en=1, go to RUN.
REQ-019 RUN: en=1; if dir_o != dir_q, go to BRAKE if duty > 0, else DEAD; otherwise on each ramp tick duty steps by exactly 1 toward speed_o, saturating at the target (no overshoot, no wrap at 0 or 15).
REQ-020 RUN: if speed_o == 0 and duty == 0, go to IDLE (en=0).
REQ-021 BRAKE: en=1; duty decrements by 1 per ramp tick regardless of speed_o; at duty == 0 go to DEAD.
REQ-022 A direction flip back to dir_q during BRAKE SHALL NOT abort it; the sequence completes through DEAD.
REQ-023 DEAD: en=0, duty=0; hold for exactly DEAD_TIME cycles; then load dir_q <= dir_o (sampled on the exit cycle), go to RUN if speed_o != 0, else IDLE.
REQ-024 dir_q SHALL change only on IDLE->RUN or DEAD exit, and never while en=1.
REQ-025 speed_o changes in RUN retarget the ramp on the next tick without a state change.

Reset
REQ-026 While rst_n=0: state IDLE, duty=0, pwm=0, en=0, dir_q=0, PWM counter, prescaler and dead-time counter = 0.
REQ-027 Reset asserted mid-ramp or mid-DEAD SHALL abort immediately to the REQ-026 values; after release, operation resumes from IDLE on the first rising edge.

Verification
REQ-028 Ramp-up: reset, speed_o=10, dir_o=5, fault=0 -> IDLE->RUN, dir_q=5, duty reaches 10 after 10 ramp ticks (40 cycles at RAMP_DIV=4), pwm high 10 of every 16 cycles.
REQ-029 Reversal: at duty=10, dir_o 5->6 -> BRAKE, duty 10->0 in 10 ticks, en=0 for 8 cycles, dir_q=6, RUN ramp back to 10; pwm never high while en=0.
REQ-030 Fault: in RUN at duty=15, fault=3'b010 -> next edge FAULT, pwm=0, en=0, duty=0; fault=0 -> IDLE, then RUN re-ramps from 0.
REQ-031 Stop: in RUN at duty=6, speed_o=0 -> duty steps down to 0 over 6 ticks, then IDLE with en=0 and dir_q unchanged.
REQ-032 Retarget and saturation: ramping toward 15, change speed_o to 3 at duty=8 -> duty stops rising at the next tick and falls to 3 with no undershoot; speed_o=15 held -> duty saturates at 15.
REQ-033 Mid-operation reset: pulse rst_n low during DEAD -> all outputs at reset values at once, no dir_q update; release with speed_o=15 -> IDLE->RUN with dir_q=dir_o.
